d_ff: RTL and testbench
=======================

D_FF -- requirements
Module: d_ff

Interface
REQ-001 Parameter WIDTH, default 1: data width in bits, legal range 1..64.
REQ-002 Parameter RST_VAL, default all-zeros (WIDTH bits): value loaded into Q on reset.
REQ-003 Parameter HAS_EN, default 0: when 1, the en port gates loading; when 0, en is ignored and every edge loads.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset; asynchronous, active-high.
REQ-006 Port D, input, WIDTH bits: data sampled at the rising edge of clk.
REQ-007 Port en, input, 1 bit: load enable; used only when HAS_EN=1.
REQ-008 Port clr, input, 1 bit: synchronous clear, active-high; loads RST_VAL at the next rising edge.
REQ-009 Port Q, output, WIDTH bits: registered data.
REQ-010 Port Qbar, output, WIDTH bits: bitwise complement of Q.

Function
REQ-011 On each rising clk edge with rst=0, Q SHALL take a new value by priority: clr=1 -> RST_VAL; else (HAS_EN=0 or en=1) -> D; else Q holds.
REQ-012 Latency SHALL be exactly one clock: D present before an edge appears on Q after that edge and stays stable until the next edge.
REQ-013 Qbar SHALL equal ~Q at all times, including during and after reset; it SHALL NOT be a separately clocked register that can disagree with Q.
REQ-014 Q SHALL NOT change between clock edges when rst=0, regardless of activity on D, en or clr.
REQ-015 D changing in the same delta as the rising edge SHALL be treated as a setup violation; the bench SHALL change D away from rising edges.
REQ-016 When clr=1 and en=0 at the same edge, clr SHALL win and Q becomes RST_VAL.
REQ-017 Each bit SHALL behave independently; no carry or interaction between bits.

Reset
REQ-018 While rst=1, Q SHALL be RST_VAL and Qbar SHALL be ~RST_VAL, immediately, with no clock edge needed.
REQ-019 rst asserted between edges SHALL force Q to RST_VAL at once, discarding the value loaded at the previous edge.
REQ-020 After rst is released, the first load SHALL occur on the first rising edge at which rst=0; an edge coincident with rst deassertion SHALL NOT load.
REQ-021 The outputs before the first reset or clock edge are undefined; the bench SHALL NOT check them.

Structure
REQ-022 Package d_ff_pkg SHALL hold the default WIDTH constant (1), the maximum WIDTH constant (64) and a helper constant for the all-zeros default RST_VAL.
REQ-023 A single-bit storage sub-module, d_ff_cell (ports clk, rst, rst_val, d, ld, clr, q), SHALL be instantiated WIDTH times from a generate loop.
REQ-024 d_ff SHALL contain only parameter checks, the generate loop, en gating and the Qbar inversion.
REQ-025 A WIDTH outside 1..64 SHALL stop elaboration with an error.

Verification
REQ-026 Clock period 10 ns with clk=0 at t=0, so rising edges fall at 5, 15, 25 and 35 ns. WIDTH=1, HAS_EN=0, rst pulsed before t=0. D=0,1,0,1 applied at t=0,10,20,30 -> samples at t=10,20,30,40 read Q=0,1,0,1 and Qbar=1,0,1,0.
REQ-027 WIDTH=8, RST_VAL=8'hA5, Q=8'h3C: assert rst mid-cycle -> Q=8'hA5 and Qbar=8'h5A immediately. Release rst, D=8'hFF -> Q=8'hFF after the next edge.
REQ-028 HAS_EN=1, Q=8'h11, en=0, D=8'h22 for 3 edges -> Q stays 8'h11. Set en=1 -> Q=8'h22 after one edge.
REQ-029 clr=1, en=0, D=8'h77 at one edge -> Q=RST_VAL. clr=0, en=1 -> Q=8'h77 on the next edge.
REQ-030 Toggle D several times between edges with en=1 -> Q changes only at rising edges. Check Qbar==~Q on every sample throughout.

Source files
------------

// File: rtl/d_ff_pkg.sv
// Shared constants for the parameterized D flip-flop: width limits and the
// all-zeros reset value default.
package d_ff_pkg;

    localparam int DFF_WIDTH_DEF = 1;
    localparam int DFF_WIDTH_MAX = 64;

    // Sliced down to WIDTH by the top to form the default reset value.
    localparam logic [DFF_WIDTH_MAX-1:0] DFF_RST_ZERO = '0;

endpackage

// File: rtl/d_ff_cell.sv
// Single-bit storage element: async reset, sync clear over load, hold otherwise.
module d_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic d,
    input  logic ld,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= rst_val;
        else if (clr)
            q <= rst_val;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/d_ff.sv
// Parameterized D register built from per-bit cells; optional load enable,
// synchronous clear and a combinational complement output.
module d_ff
    import d_ff_pkg::*;
#(
    parameter int               WIDTH   = DFF_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = DFF_RST_ZERO[WIDTH-1:0],
    parameter bit               HAS_EN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
);

    if (WIDTH < 1 || WIDTH > DFF_WIDTH_MAX) begin : g_bad_width
        $error("d_ff: WIDTH=%0d outside 1..%0d", WIDTH, DFF_WIDTH_MAX);
    end

    logic ld;

    // Without an enable every edge loads, so en is simply not selected.
    assign ld = HAS_EN ? en : 1'b1;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        d_ff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_VAL[gi]),
            .d       (D[gi]),
            .ld      (ld),
            .clr     (clr),
            .q       (Q[gi])
        );
    end

    // Derived from Q so the pair can never disagree, even mid-reset.
    assign Qbar = ~Q;

endmodule

// File: tb/tb_d_ff.sv
// Randomized and directed checks of d_ff in three configurations against a
// behavioural model of the load/clear/reset rules.
module tb_d_ff;
    timeunit 1ns;
    timeprecision 100ps;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] d   = 8'h00;

    logic       qa, qba;
    logic [7:0] qb, qbb, qc, qbc;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    d_ff #(.WIDTH(1)) u_a (
        .clk(clk), .rst(rst), .D(d[0]), .en(en), .clr(clr), .Q(qa), .Qbar(qba)
    );
    d_ff #(.WIDTH(8), .RST_VAL(8'hA5), .HAS_EN(1'b1)) u_b (
        .clk(clk), .rst(rst), .D(d), .en(en), .clr(clr), .Q(qb), .Qbar(qbb)
    );
    d_ff #(.WIDTH(8), .RST_VAL(8'h3C), .HAS_EN(1'b0)) u_c (
        .clk(clk), .rst(rst), .D(d), .en(en), .clr(clr), .Q(qc), .Qbar(qbc)
    );

    // Reference: reset dominates, then clear, then load when enabled.
    logic       ea;
    logic [7:0] eb, ec;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ea <= 1'b0;
            eb <= 8'hA5;
            ec <= 8'h3C;
        end else begin
            ea <= clr ? 1'b0  : d[0];
            eb <= clr ? 8'hA5 : (en ? d : eb);
            ec <= clr ? 8'h3C : d;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_qa"},   qa,  ea);
        chk({tag, "_qba"},  qba, 1'(~ea));
        chk({tag, "_qb"},   qb,  eb);
        chk({tag, "_qbb"},  qbb, 8'(~eb));
        chk({tag, "_qc"},   qc,  ec);
        chk({tag, "_qbc"},  qbc, 8'(~ec));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [3:0] pat = 4'b1010;   // D sequence 0,1,0,1 for the 1-bit instance

    initial begin
        // Reset pulse ahead of the first edge; outputs visible without a clock.
        #1 rst = 1'b1;
        #1 chk_all("rst_hold");
        chk("rst_b_const", qb, 8'hA5);
        chk("rst_bb_const", qbb, 8'h5A);
        #1 rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("seq_q", qa, pat[i]);
            chk("seq_qbar", qba, !pat[i]);
            chk_all("seq");
            if (i < 3) d[0] = pat[i+1];
        end

        // Async reset mid-cycle discards the loaded 3C.
        d = 8'h3C; en = 1'b1;
        @(negedge clk);
        chk("load_3c", qb, 8'h3C);
        #2 rst = 1'b1;
        #1 chk("midrst_q", qb, 8'hA5);
        chk("midrst_qbar", qbb, 8'h5A);
        chk_all("midrst");
        #1 rst = 1'b0;
        d = 8'hFF;
        @(negedge clk);
        chk("post_rst_ff", qb, 8'hFF);
        chk_all("post_rst");

        // Enable gating.
        d = 8'h11;
        @(negedge clk);
        chk("load_11", qb, 8'h11);
        en = 1'b0; d = 8'h22;
        repeat (3) begin
            @(negedge clk);
            chk("hold_11", qb, 8'h11);
            chk("noen_c_22", qc, 8'h22);
            chk_all("hold");
        end
        en = 1'b1;
        @(negedge clk);
        chk("load_22", qb, 8'h22);

        // Clear beats a disabled load, then normal load resumes.
        d = 8'h77; en = 1'b0; clr = 1'b1;
        @(negedge clk);
        chk("clr_b", qb, 8'hA5);
        chk("clr_c", qc, 8'h3C);
        chk_all("clr");
        clr = 1'b0; en = 1'b1;
        @(negedge clk);
        chk("after_clr", qb, 8'h77);

        // D toggling between edges must not reach Q.
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            #1 chk_all("tog1");
            d = 8'($urandom);
            #2 chk_all("tog2");
            d = 8'($urandom);
            @(negedge clk);
            chk_all("tog_edge");
        end

        for (int i = 0; i < 300; i++) begin
            d   = 8'($urandom);
            en  = 1'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) begin
                #2 rst = 1'b1;
                #1 chk_all("rnd_rst");
                #1 rst = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                #2 d = 8'($urandom);
                #1 chk_all("rnd_tog");
            end
            @(negedge clk);
            chk_all("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
